// File: rtl/dm_responder.sv
// dm_responder: single-port data-memory responder for a CPU load/store unit.
//
// Captures one request in IDLE, optionally inserts WAIT_CYCLES wait states,
// then returns a one-cycle ack in RESP with load data (or a fault flag).
// Stores are committed on the clock edge that ends RESP.
//
// Parameters:
//   WAIT_CYCLES  wait states between capture and response (0..15)
//   DEPTH_LOG2   word-address width (memory holds 2**DEPTH_LOG2 words)
//
// Ports:
//   clk    sole clock, rising edge
//   rst    synchronous active-low reset
//   req    request valid, sampled only in IDLE
//   we     1 = store, 0 = load
//   addr   word address
//   boff   byte offset within the word
//   lsop   access size: 00 word, 01 halfword, 10 byte, 11 illegal
//   sext   load extension: 1 = sign, 0 = zero
//   wdata  right-justified store data
//   ack    one-cycle response pulse
//   rdata  load data, zero except during a load response
//   err    access fault, valid with ack
//   busy   high whenever not IDLE
//
// Configuration macro:
//   DM_ALIGN_CHECK_EN  defined: misaligned/illegal accesses fault (err=1,
//                      no write, rdata=0). Undefined: err is always 0, word
//                      accesses ignore boff, halfwords ignore boff[0], and
//                      lsop=11 behaves as a word access.
module dm_responder #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned DEPTH_LOG2  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [1:0]            boff,
    input  logic [1:0]            lsop,
    input  logic                  sext,
    input  logic [31:0]           wdata,
    output logic                  ack,
    output logic [31:0]           rdata,
    output logic                  err,
    output logic                  busy
);

    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic                    ack_q;
    logic [31:0]             rdata_q;
    logic                    err_q;

    logic                    we_q;
    logic [DEPTH_LOG2-1:0]   addr_q;
    logic [1:0]              boff_q;
    logic [1:0]              lsop_q;
    logic                    sext_q;
    logic [31:0]             wdata_q;

    logic [31:0]             mem [DEPTH];

    // Size actually used for lane selection.
    function automatic logic [1:0] eff_size(input logic [1:0] op);
`ifdef DM_ALIGN_CHECK_EN
        return op;
`else
        return (op == 2'b11) ? 2'b00 : op;
`endif
    endfunction

`ifdef DM_ALIGN_CHECK_EN
    function automatic logic is_fault(input logic [1:0] op, input logic [1:0] bo);
        return (op == 2'b11) || (op == 2'b01 && bo[0]) || (op == 2'b00 && bo != 2'b00);
    endfunction
`endif

    function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] bo);
        case (sz)
            2'b00:   return 4'b1111;
            2'b01:   return bo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b0001 << bo;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            2'b00:   return wd;
            2'b01:   return {2{wd[15:0]}};
            default: return {4{wd[7:0]}};
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [1:0] sz, input logic [1:0] bo,
                                             input logic sx, input logic [31:0] word);
        logic [15:0] half;
        logic [7:0]  byt;
        half = bo[1] ? word[31:16] : word[15:0];
        byt  = word[{bo, 3'b000} +: 8];
        case (sz)
            2'b00:   return word;
            2'b01:   return {{16{sx & half[15]}}, half};
            default: return {{24{sx & byt[7]}}, byt};
        endcase
    endfunction

    // Response data is registered on entry to RESP. When entering straight
    // from IDLE the holding registers are being loaded on that same edge, so
    // the response is computed from the live inputs instead.
    logic                  src_we;
    logic                  src_sext;
    logic [DEPTH_LOG2-1:0] src_addr;
    logic [1:0]            src_boff;
    logic [1:0]            src_lsop;
    logic [1:0]            src_size;
    logic                  src_fault;
    logic [31:0]           src_word;
    logic [31:0]           resp_rdata;

    logic [1:0]            hold_size;
    logic                  hold_fault;
    logic [3:0]            hold_be;
    logic [31:0]           hold_lanes;

    always_comb begin
        if (state_q == IDLE) begin
            src_we   = we;
            src_sext = sext;
            src_addr = addr;
            src_boff = boff;
            src_lsop = lsop;
        end else begin
            src_we   = we_q;
            src_sext = sext_q;
            src_addr = addr_q;
            src_boff = boff_q;
            src_lsop = lsop_q;
        end
        src_size = eff_size(src_lsop);
`ifdef DM_ALIGN_CHECK_EN
        src_fault  = is_fault(src_lsop, src_boff);
        hold_fault = is_fault(lsop_q, boff_q);
`else
        src_fault  = 1'b0;
        hold_fault = 1'b0;
`endif
        src_word   = mem[src_addr];
        resp_rdata = (src_we || src_fault) ? '0 : load_ext(src_size, src_boff, src_sext, src_word);

        hold_size  = eff_size(lsop_q);
        hold_be    = byte_en(hold_size, boff_q);
        hold_lanes = store_lanes(hold_size, wdata_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            boff_q  <= '0;
            lsop_q  <= '0;
            sext_q  <= 1'b0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ack_q   <= 1'b0;
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        boff_q  <= boff;
                        lsop_q  <= lsop;
                        sext_q  <= sext;
                        wdata_q <= wdata;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= RESP;
                            ack_q   <= 1'b1;
                            rdata_q <= resp_rdata;
                            err_q   <= src_fault;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                        ack_q   <= 1'b1;
                        rdata_q <= resp_rdata;
                        err_q   <= src_fault;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Memory is not reset; a reset edge during RESP suppresses the write.
    always_ff @(posedge clk) begin
        if (rst && state_q == RESP && we_q && !hold_fault) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (hold_be[i]) begin
                    mem[addr_q][8*i +: 8] <= hold_lanes[8*i +: 8];
                end
            end
        end
    end

    assign ack   = ack_q;
    assign rdata = rdata_q;
    assign err   = err_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;

    localparam int unsigned W = 2;
    localparam logic [1:0] LW = 2'b00;
    localparam logic [1:0] LH = 2'b01;
    localparam logic [1:0] LB = 2'b10;
    localparam logic [1:0] LX = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        req = 1'b0, we = 1'b0, sext = 1'b0;
    logic [9:0]  addr = '0;
    logic [1:0]  boff = '0, lsop = '0;
    logic [31:0] wdata = '0;
    logic        ack, err, busy;
    logic [31:0] rdata;

    logic        req0 = 1'b0, we0 = 1'b0, sext0 = 1'b0;
    logic [9:0]  addr0 = '0;
    logic [1:0]  boff0 = '0, lsop0 = '0;
    logic [31:0] wdata0 = '0;
    logic        ack0, err0, busy0;
    logic [31:0] rdata0;

    dm_responder #(.WAIT_CYCLES(W), .DEPTH_LOG2(10)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .boff(boff),
        .lsop(lsop), .sext(sext), .wdata(wdata),
        .ack(ack), .rdata(rdata), .err(err), .busy(busy)
    );

    dm_responder #(.WAIT_CYCLES(0), .DEPTH_LOG2(10)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .boff(boff0),
        .lsop(lsop0), .sext(sext0), .wdata(wdata0),
        .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned due;
    } exp_t;

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [1:0]  boff;
        logic [1:0]  lsop;
        logic        sext;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    // Zero-wait instance stimulus: odd entries arrive while busy and must be ignored.
    logic        v0_we [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] v0_wd [6] = '{32'h11111111, 32'hBAD0BAD0, 32'h0, 32'h22222222, 32'h0, 32'h33333333};
    logic [31:0] e0_rd [7] = '{32'h0, 32'h0, 32'h0, 32'h11111111, 32'h0, 32'h11111111, 32'h0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic w, input int a, input logic [1:0] b,
                                input logic [1:0] op, input logic sx, input logic [31:0] wd,
                                input logic [31:0] er, input logic ee);
        vec_t v;
        v.we = w; v.addr = 10'(a); v.boff = b; v.lsop = op; v.sext = sx;
        v.wdata = wd; v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    // Scoreboard consumer: every ack must match the oldest expectation,
    // including its arrival cycle; outside ack the outputs must be quiet.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ack === 1'b1) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("rdata", rdata, mon_e.rdata);
                    chk("err", 32'(err), 32'(mon_e.err));
                    chk("latency", cyc, mon_e.due);
                end
            end else begin
                chk("idle_rdata", rdata, 32'h0);
                chk("idle_err", 32'(err), 32'h0);
            end
        end
    end

    task automatic drive(input vec_t v);
        we = v.we; addr = v.addr; boff = v.boff; lsop = v.lsop; sext = v.sext; wdata = v.wdata;
        req = 1'b1;
    endtask

    task automatic scramble();
        req = 1'b0;
        we = 1'($urandom); addr = 10'($urandom); boff = 2'($urandom);
        lsop = 2'($urandom); sext = 1'($urandom); wdata = $urandom;
    endtask

    task automatic issue(input vec_t v);
        exp_t e;
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        e.rdata = v.exp_rdata; e.err = v.exp_err; e.due = cyc + W;
        sbq.push_back(e);
        scramble();
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sbq.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("drain_timeout", 32'(sbq.size()), 32'h0);
        sbq.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        vec_t v;
        exp_t e;

        vecs.push_back(mk(1'b1, 5, 2'd0, LW, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 5, 2'd0, LW, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0));
        vecs.push_back(mk(1'b1, 5, 2'd2, LB, 1'b0, 32'h00000080, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 5, 2'd2, LB, 1'b1, 32'h0,        32'hFFFFFF80, 1'b0));
        vecs.push_back(mk(1'b0, 5, 2'd2, LB, 1'b0, 32'h0,        32'h00000080, 1'b0));
        vecs.push_back(mk(1'b0, 5, 2'd0, LW, 1'b0, 32'h0,        32'hDE80BEEF, 1'b0));
        vecs.push_back(mk(1'b1, 9, 2'd0, LW, 1'b0, 32'h0,        32'h0,        1'b0));
        vecs.push_back(mk(1'b1, 9, 2'd2, LH, 1'b0, 32'h00001234, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 9, 2'd0, LW, 1'b0, 32'h0,        32'h12340000, 1'b0));
        vecs.push_back(mk(1'b0, 9, 2'd0, LH, 1'b1, 32'h0,        32'h00000000, 1'b0));
        vecs.push_back(mk(1'b0, 9, 2'd2, LH, 1'b1, 32'h0,        32'h00001234, 1'b0));
        vecs.push_back(mk(1'b1, 9, 2'd0, LH, 1'b0, 32'hFFFF8001, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 9, 2'd0, LH, 1'b1, 32'h0,        32'hFFFF8001, 1'b0));
        vecs.push_back(mk(1'b0, 9, 2'd0, LH, 1'b0, 32'h0,        32'h00008001, 1'b0));
        vecs.push_back(mk(1'b1, 9, 2'd3, LB, 1'b0, 32'hFFFFFF7F, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 9, 2'd0, LW, 1'b0, 32'h0,        32'h7F348001, 1'b0));
        vecs.push_back(mk(1'b0, 9, 2'd1, LB, 1'b1, 32'h0,        32'hFFFFFF80, 1'b0));
        vecs.push_back(mk(1'b0, 9, 2'd3, LB, 1'b0, 32'h0,        32'h0000007F, 1'b0));
`ifdef DM_ALIGN_CHECK_EN
        vecs.push_back(mk(1'b1, 5, 2'd1, LW, 1'b0, 32'h01020304, 32'h0,        1'b1));
        vecs.push_back(mk(1'b0, 5, 2'd0, LW, 1'b0, 32'h0,        32'hDE80BEEF, 1'b0));
        vecs.push_back(mk(1'b1, 9, 2'd3, LH, 1'b0, 32'h0000FFFF, 32'h0,        1'b1));
        vecs.push_back(mk(1'b0, 9, 2'd1, LH, 1'b1, 32'h0,        32'h0,        1'b1));
        vecs.push_back(mk(1'b0, 9, 2'd0, LX, 1'b0, 32'h0,        32'h0,        1'b1));
        vecs.push_back(mk(1'b0, 9, 2'd0, LW, 1'b0, 32'h0,        32'h7F348001, 1'b0));
`else
        vecs.push_back(mk(1'b0, 5, 2'd3, LW, 1'b0, 32'h0,        32'hDE80BEEF, 1'b0));
        vecs.push_back(mk(1'b0, 5, 2'd0, LX, 1'b0, 32'h0,        32'hDE80BEEF, 1'b0));
        vecs.push_back(mk(1'b0, 9, 2'd3, LH, 1'b1, 32'h0,        32'h00007F34, 1'b0));
        vecs.push_back(mk(1'b1, 7, 2'd1, LW, 1'b0, 32'hA5A5A5A5, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 7, 2'd0, LW, 1'b0, 32'h0,        32'hA5A5A5A5, 1'b0));
`endif

        // Reset state of both instances.
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack",   32'(ack),  32'h0);
        chk("rst_rdata", rdata,     32'h0);
        chk("rst_err",   32'(err),  32'h0);
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_busy0", 32'(busy0), 32'h0);
        rst = 1'b1;
        mon_en = 1'b1;

        foreach (vecs[i]) begin
            issue(vecs[i]);
            @(negedge clk);
            chk("busy_after_req", 32'(busy), 32'h1);
            drain();
        end

        // Reset during WAIT of a store: no ack, busy drops, word unchanged.
        @(negedge clk);
        drive(mk(1'b1, 5, 2'd0, LW, 1'b0, 32'h12345678, 32'h0, 1'b0));
        @(posedge clk);
        #1;
        scramble();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("wait_rst_busy", 32'(busy), 32'h0);
        chk("wait_rst_ack",  32'(ack),  32'h0);
        repeat (5) @(negedge clk);
        issue(mk(1'b0, 5, 2'd0, LW, 1'b0, 32'h0, 32'hDE80BEEF, 1'b0));
        drain();

        // Reset during RESP of a store: ack seen, write suppressed.
        @(negedge clk);
        drive(mk(1'b1, 5, 2'd0, LW, 1'b0, 32'hCAFEF00D, 32'h0, 1'b0));
        @(posedge clk);
        #1;
        e.rdata = 32'h0; e.err = 1'b0; e.due = cyc + W;
        sbq.push_back(e);
        scramble();
        repeat (3) @(negedge clk);
        #1;
        chk("resp_rst_ack", 32'(ack), 32'h1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("resp_rst_pending", 32'(sbq.size()), 32'h0);
        sbq.delete();
        issue(mk(1'b0, 5, 2'd0, LW, 1'b0, 32'h0, 32'hDE80BEEF, 1'b0));
        drain();

        // Zero-wait instance, req held high: one transaction every 2 cycles.
        for (int j = 0; j <= 6; j++) begin
            @(negedge clk);
            if (j > 0) begin
                chk("w0_ack",   32'(ack0),  32'(j % 2));
                chk("w0_busy",  32'(busy0), 32'(j % 2));
                chk("w0_rdata", rdata0,     e0_rd[j]);
                chk("w0_err",   32'(err0),  32'h0);
            end
            if (j < 6) begin
                we0 = v0_we[j]; addr0 = 10'd3; boff0 = 2'd0; lsop0 = LW;
                sext0 = 1'b0; wdata0 = v0_wd[j]; req0 = 1'b1;
            end else begin
                req0 = 1'b0;
            end
        end

        v = mk(1'b0, 0, 2'd0, LW, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(v);
        req = 1'b0;
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
